// File: rtl/key_conditioner_pkg.sv
// Shared constants for the push-button conditioning slice:
// key count, FSM state encoding, default debounce length and a priority helper.
package key_conditioner_pkg;

    localparam int NUM_KEYS                = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HELD = 1'b1;

    // Isolates the lowest set bit (two's-complement trick).
    function automatic logic [NUM_KEYS-1:0] lowest_onehot(
        input logic [NUM_KEYS-1:0] v
    );
        return v & (~v + NUM_KEYS'(1));
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key synchroniser + debouncer.
// Ports: clock, reset (async, active-high), raw_n (raw active-low button),
//        level (debounced, 1 = pressed), rise (one-cycle strobe on level 0->1).
module key_debounce
    import key_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_n,
    output logic level,
    output logic rise
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          stable_q;
    logic          stable_d;
    logic          rise_q;
    logic          rise_d;
    logic          pressed;

    assign pressed = ~sync2_q;

    // Count only while the synchronised level disagrees with the stable one;
    // any agreeing cycle restarts the count, so short glitches never land.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        rise_d   = 1'b0;
        if (pressed != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = pressed;
                rise_d   = pressed;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            sync1_q  <= raw_n;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
        end
    end

    assign level = stable_q;
    assign rise  = rise_q;

endmodule

// File: rtl/key_conditioner.sv
// Conditions the four active-low KEY buttons into one-hot press strobes.
// Ports: clock, reset (async, active-high), key_n[3:0] (raw buttons),
//        key_pulse[3:0] (one-cycle one-hot press), key_held (FSM in HELD),
//        key_state[3:0] (debounced levels, 1 = pressed).
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_pulse,
    output logic                key_held,
    output logic [NUM_KEYS-1:0] key_state
);

    logic [NUM_KEYS-1:0] rise;
    logic [0:0]          state_q;
    logic [0:0]          state_d;
    logic [NUM_KEYS-1:0] pulse_q;
    logic [NUM_KEYS-1:0] pulse_d;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clock (clock),
            .reset (reset),
            .raw_n (key_n[i]),
            .level (key_state[i]),
            .rise  (rise[i])
        );
    end

    // One press at a time: leave HELD only once every key is released,
    // so rises arriving in HELD are dropped for good.
    always_comb begin
        state_d = state_q;
        pulse_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (|rise) begin
                    pulse_d = lowest_onehot(rise);
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                if (key_state == '0) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pulse_q <= '0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
        end
    end

    assign key_pulse = pulse_q;
    assign key_held  = (state_q == ST_HELD);

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES = 4.
// Expected pulses (value + cycle) are queued at stimulus time and popped on output.
module tb_key_conditioner;

    localparam int D = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] key_n = 4'hF;
    logic [3:0] key_pulse;
    logic       key_held;
    logic [3:0] key_state;

    int cyc    = 0;
    int total  = 0;
    int passed = 0;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [3:0] seen_state;

    key_conditioner #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .key_n     (key_n),
        .key_pulse (key_pulse),
        .key_held  (key_held),
        .key_state (key_state)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every nonzero pulse must match the head of the scoreboard.
    always @(negedge clock) begin
        if (!reset && key_pulse !== 4'b0000) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'(key_pulse), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_val", 32'(key_pulse), 32'(mon_e.val));
                check("pulse_cyc", cyc, mon_e.cyc);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            seen_state |= key_state;
        end
    endtask

    task automatic drive(input int k, input logic v);
        @(negedge clock);
        key_n[k] = v;
    endtask

    // First sampling edge is cyc+1; pulse visible at negedge after edge cyc+3+D.
    task automatic expect_pulse(input int k);
        exp_t       e;
        logic [3:0] oh;
        oh    = 4'b0001 << k;
        e.cyc = cyc + 3 + D;
        e.val = oh;
        sb.push_back(e);
    endtask

    initial begin
        seen_state = '0;

        // Reset state
        step(3);
        check("rst_pulse", 32'(key_pulse), 32'd0);
        check("rst_state", 32'(key_state), 32'd0);
        check("rst_held", 32'(key_held), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        step(3);

        // Clean press of key 2
        drive(2, 1'b0);
        expect_pulse(2);
        step(20);
        check("s1_state", 32'(key_state), 32'h4);
        check("s1_held", 32'(key_held), 32'd1);
        drive(2, 1'b1);
        step(6);
        check("s1_held_pre_fall", 32'(key_held), 32'd1);
        step(1);
        check("s1_held_fall", 32'(key_held), 32'd0);
        step(8);

        // Glitches on key 0: 3 low, 1 high, 3 low, high
        seen_state = '0;
        drive(0, 1'b0);
        step(2);
        drive(0, 1'b1);
        drive(0, 1'b0);
        step(2);
        drive(0, 1'b1);
        step(12);
        check("s2_glitch_state", 32'(seen_state[0]), 32'd0);
        check("s2_held", 32'(key_held), 32'd0);

        // Keys 3 and 1 together: key 1 wins
        @(negedge clock);
        key_n[3] = 1'b0;
        key_n[1] = 1'b0;
        expect_pulse(1);
        step(12);
        check("s3_state", 32'(key_state), 32'ha);
        check("s3_held", 32'(key_held), 32'd1);
        @(negedge clock);
        key_n = 4'hF;
        step(12);
        check("s3_idle", 32'(key_held), 32'd0);

        // Overlapping keys 0 and 1: only key 0 pulses
        drive(0, 1'b0);
        expect_pulse(0);
        step(10);
        drive(1, 1'b0);
        step(10);
        drive(0, 1'b1);
        step(10);
        check("s4_state_k1", 32'(key_state), 32'h2);
        check("s4_still_held", 32'(key_held), 32'd1);
        drive(1, 1'b1);
        step(10);
        check("s4_idle", 32'(key_held), 32'd0);
        step(4);

        // Reset mid-debounce with key 2 held through reset release
        drive(2, 1'b0);
        step(2);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("s5_rst_pulse", 32'(key_pulse), 32'd0);
        check("s5_rst_state", 32'(key_state), 32'd0);
        check("s5_rst_held", 32'(key_held), 32'd0);
        step(3);
        check("s5_rst_state2", 32'(key_state), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        expect_pulse(2);
        step(10);
        check("s5_held", 32'(key_held), 32'd1);
        drive(2, 1'b1);
        step(12);

        // Sequential presses 0..3
        for (int k = 0; k < 4; k++) begin
            drive(k, 1'b0);
            expect_pulse(k);
            step(10);
            drive(k, 1'b1);
            step(12);
        end

        step(5);
        check("sb_empty", sb.size(), 32'd0);
        check("end_pulse", 32'(key_pulse), 32'd0);
        check("end_state", 32'(key_state), 32'd0);
        check("end_held", 32'(key_held), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
